// File: rtl/acorn_init_seq_if.sv
// Message-stream bundle between the ACORN init sequencer and the state-update core.
// The master presents one W-bit beat plus its ca/cb lanes and framing; the slave answers with m_ready.
interface acorn_init_seq_if #(
    parameter int W     = 1,
    parameter int CNT_W = 11
);
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_data;
    logic [W-1:0]     ca_out;
    logic [W-1:0]     cb_out;
    logic             m_first;
    logic             m_last;
    logic [CNT_W-1:0] beat_idx;

    modport master (
        output m_valid, m_data, ca_out, cb_out, m_first, m_last, beat_idx,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, ca_out, cb_out, m_first, m_last, beat_idx,
        output m_ready
    );
endinterface

// File: rtl/acorn_init_seq.sv
// ACORN-128 initialization sequencer: latches key/IV on start and streams the
// initialization message W bits per beat over a valid/ready handshake.
module acorn_init_seq #(
    parameter int W          = 1,
    parameter int KEY_W      = 128,
    parameter int IV_W       = 128,
    parameter int INIT_STEPS = 1792,
    localparam int BEATS     = INIT_STEPS / W,
    localparam int CNT_W     = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] key_in,
    input  logic [IV_W-1:0]  iv_in,
    output logic             busy,
    output logic             done,
    acorn_init_seq_if.master m
);

    localparam int KIDX_W     = $clog2(KEY_W);
    localparam int SEG        = KEY_W / W;               // beats per key-sized block
    localparam int TWEAK_BEAT = (KEY_W + IV_W) / W;
    localparam int TWEAK_LANE = (KEY_W + IV_W) % W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [KEY_W-1:0] key_lat;
    logic [IV_W-1:0]  iv_lat;
    logic             valid_q;
    logic [W-1:0]     data_q;
    logic             first_q;
    logic             last_q;
    logic             busy_q;
    logic             done_q;

    // Because W divides KEY_W, a beat never straddles the key/IV/key-repeat regions,
    // so each beat is one aligned W-bit slice plus the single-step tweak at step KEY_W+IV_W.
    function automatic logic [W-1:0] beat_data(input logic [CNT_W-1:0] n,
                                               input logic [KEY_W-1:0] k,
                                               input logic [IV_W-1:0]  v);
        int               n_i;
        logic [KIDX_W-1:0] off;
        logic [W-1:0]     d;
        n_i = int'(n);
        off = KIDX_W'((n_i % SEG) * W);
        if (n_i >= SEG && n_i < 2 * SEG) d = v[off +: W];
        else                             d = k[off +: W];
        if (n_i == TWEAK_BEAT) d[TWEAK_LANE] = ~d[TWEAK_LANE];
        return d;
    endfunction

    // NOTE: all state here is sequential, so every assignment uses <= to avoid
    // ordering races between registers updated on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            key_lat <= '0;
            iv_lat  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        key_lat <= key_in;
                        iv_lat  <= iv_in;
                        cnt     <= '0;
                        valid_q <= 1'b1;
                        // First beat comes straight from the inputs being latched this edge.
                        data_q  <= beat_data('0, key_in, iv_in);
                        first_q <= 1'b1;
                        last_q  <= (LAST == '0);
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (valid_q && m.m_ready) begin
                        if (cnt == LAST) begin
                            state   <= DONE;
                            cnt     <= '0;
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            first_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            data_q  <= beat_data(cnt + 1'b1, key_lat, iv_lat);
                            first_q <= 1'b0;
                            last_q  <= (cnt + 1'b1 == LAST);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m.m_valid  = valid_q;
    assign m.m_data   = data_q;
    assign m.ca_out   = {W{valid_q}};
    assign m.cb_out   = {W{valid_q}};
    assign m.m_first  = first_q;
    assign m.m_last   = last_q;
    assign m.beat_idx = cnt;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_acorn_init_seq.sv
// Self-checking bench for acorn_init_seq: three widths (W=1, 8, 32) share one clock and
// one stimulus process; every beat is compared against a step-by-step message model.
module tb_acorn_init_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, abort, ready;
    int           sel;
    logic [127:0] key_in, iv_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic         cap_valid;
    logic [127:0] cap [int];

    always #5 clk = ~clk;

    acorn_init_seq_if #(.W(1),  .CNT_W(11)) if0 ();
    acorn_init_seq_if #(.W(8),  .CNT_W(8))  if1 ();
    acorn_init_seq_if #(.W(32), .CNT_W(6))  if2 ();

    logic busy0, busy1, busy2, done0, done1, done2;

    assign if0.m_ready = ready && (sel == 0);
    assign if1.m_ready = ready && (sel == 1);
    assign if2.m_ready = ready && (sel == 2);

    acorn_init_seq #(.W(1)) u0 (
        .clk(clk), .rst(rst), .start(start && (sel == 0)), .abort(abort && (sel == 0)),
        .key_in(key_in), .iv_in(iv_in), .busy(busy0), .done(done0), .m(if0)
    );
    acorn_init_seq #(.W(8)) u1 (
        .clk(clk), .rst(rst), .start(start && (sel == 1)), .abort(abort && (sel == 1)),
        .key_in(key_in), .iv_in(iv_in), .busy(busy1), .done(done1), .m(if1)
    );
    acorn_init_seq #(.W(32)) u2 (
        .clk(clk), .rst(rst), .start(start && (sel == 2)), .abort(abort && (sel == 2)),
        .key_in(key_in), .iv_in(iv_in), .busy(busy2), .done(done2), .m(if2)
    );

    logic         o_valid, o_first, o_last, o_busy, o_done;
    logic [127:0] o_data, o_ca, o_cb;
    int           o_idx;

    always_comb begin
        o_valid = 1'b0; o_first = 1'b0; o_last = 1'b0; o_busy = 1'b0; o_done = 1'b0;
        o_data = '0; o_ca = '0; o_cb = '0; o_idx = 0;
        case (sel)
            0: begin
                o_valid = if0.m_valid; o_first = if0.m_first; o_last = if0.m_last;
                o_data = 128'(if0.m_data); o_ca = 128'(if0.ca_out); o_cb = 128'(if0.cb_out);
                o_idx = int'(if0.beat_idx); o_busy = busy0; o_done = done0;
            end
            1: begin
                o_valid = if1.m_valid; o_first = if1.m_first; o_last = if1.m_last;
                o_data = 128'(if1.m_data); o_ca = 128'(if1.ca_out); o_cb = 128'(if1.cb_out);
                o_idx = int'(if1.beat_idx); o_busy = busy1; o_done = done1;
            end
            default: begin
                o_valid = if2.m_valid; o_first = if2.m_first; o_last = if2.m_last;
                o_data = 128'(if2.m_data); o_ca = 128'(if2.ca_out); o_cb = 128'(if2.cb_out);
                o_idx = int'(if2.beat_idx); o_busy = busy2; o_done = done2;
            end
        endcase
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference message, written straight from the step definition.
    function automatic logic msg_bit(input logic [127:0] k, input logic [127:0] v, input int s);
        if (s < 128) return k[s];
        if (s < 256) return v[s - 128];
        if (s == 256) return ~k[0];
        return k[s % 128];
    endfunction

    function automatic logic [127:0] model_data(input logic [127:0] k, input logic [127:0] v,
                                                input int beat, input int w);
        logic [127:0] d;
        d = '0;
        for (int j = 0; j < w; j++) d[j] = msg_bit(k, v, beat * w + j);
        return d;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, o_valid, 1'b0);
        check({tag, "_busy"},  o_busy,  1'b0);
        check({tag, "_done"},  o_done,  1'b0);
        check({tag, "_idx"},   o_idx,   0);
        check({tag, "_data"},  o_data,  '0);
        check({tag, "_ca"},    o_ca,    '0);
        check({tag, "_first"}, o_first, 1'b0);
    endtask

    task automatic run_seq(input int k, input int w, input logic [127:0] key, input logic [127:0] iv,
                           input int ready_pct, input int abort_at, input int poke_at,
                           input int rst_at, input string tag);
        int           beats, beat, cycles;
        logic         xfer, fin;
        logic [127:0] mask;
        beats = 1792 / w;
        mask  = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
        sel = k; key_in = key; iv_in = iv;
        cap.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        key_in = rnd128(); iv_in = rnd128();
        beat = 0; cycles = 0; fin = 1'b0;
        while (!fin && cycles < beats * 30 + 50) begin
            ready = ($urandom_range(99) < ready_pct);
            if (beat == abort_at) begin ready = 1'b1; abort = 1'b1; end
            if (beat == poke_at) begin start = 1'b1; key_in = rnd128(); end
            if (beat == rst_at) begin
                #2 rst = 1'b0;
                #1 check_quiet({tag, "_rst"});
                check({tag, "_rst_last"}, o_last, 1'b0);
                ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
                return;
            end
            @(negedge clk);
            cap[beat] = o_data;
            check({tag, "_valid"}, o_valid, 1'b1);
            check({tag, "_idx"},   o_idx,   beat);
            check({tag, "_data"},  o_data,  model_data(key, iv, beat, w));
            check({tag, "_ca"},    o_ca,    mask);
            check({tag, "_cb"},    o_cb,    mask);
            check({tag, "_first"}, o_first, beat == 0);
            check({tag, "_last"},  o_last,  beat == beats - 1);
            check({tag, "_busy"},  o_busy,  1'b1);
            check({tag, "_done"},  o_done,  1'b0);
            @(posedge clk);
            xfer = ready;
            #1 start = 1'b0;
            cycles++;
            if (abort) begin
                abort = 1'b0;
                @(negedge clk) check_quiet({tag, "_abort"});
                @(negedge clk) check({tag, "_abort_nodone"}, o_done, 1'b0);
                return;
            end
            if (xfer) begin
                if (beat == beats - 1) fin = 1'b1;
                else beat++;
            end
        end
        check({tag, "_finished"}, fin, 1'b1);
        if (!fin) return;
        start = 1'b1;
        @(negedge clk);
        check({tag, "_done_pulse"}, o_done,  1'b1);
        check({tag, "_done_busy"},  o_busy,  1'b1);
        check({tag, "_done_valid"}, o_valid, 1'b0);
        if (ready_pct == 100) check({tag, "_latency"}, cycles, beats);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk) check_quiet({tag, "_after"});
    endtask

    initial begin
        int ones;
        rst = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0; sel = 0;
        key_in = '0; iv_in = '0;
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1 check_quiet($sformatf("reset%0d", k));
        end
        #10 rst = 1'b1;
        repeat (2) @(posedge clk);

        run_seq(0, 1, '0, '0, 100, -1, -1, -1, "w1_zero");
        ones = 0;
        for (int b = 0; b < 1792; b++) if (cap.exists(b) && cap[b][0]) ones++;
        check("w1_zero_ones", ones, 1);
        check("w1_zero_b256", cap[256], 128'h1);

        run_seq(1, 8, 128'h01, 128'hFF << 120, 100, -1, -1, -1, "w8_fixed");
        check("w8_b0",  cap[0],  128'h01);
        check("w8_b1",  cap[1],  128'h00);
        check("w8_b15", cap[15], 128'h00);
        check("w8_b31", cap[31], 128'hFF);
        check("w8_b32", cap[32], 128'h00);
        check("w8_b48", cap[48], 128'h01);

        for (int i = 0; i < 3; i++) run_seq(2, 32, rnd128(), rnd128(), 50, -1, -1, -1, "w32_rand");
        run_seq(1, 8, rnd128(), rnd128(), 60, -1, 10, -1, "w8_poke");
        run_seq(0, 1, rnd128(), rnd128(), 100, 100, -1, -1, "w1_abort");
        run_seq(0, 1, rnd128(), rnd128(), 70, -1, -1, -1, "w1_restart");
        run_seq(0, 1, rnd128(), rnd128(), 100, -1, -1, 500, "w1_rst");
        run_seq(0, 1, rnd128(), rnd128(), 100, -1, -1, -1, "w1_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acorn_init_seq.md
Name: acorn_init_seq

Overview:
- Parametrised ACORN-128 initialization sequencer.
- Latches key and IV on a start pulse, then streams the 1792-step initialization message sequence, W bits per beat, to a downstream state-update core over a valid/ready handshake.
- Emits matching all-ones ca/cb control lanes per beat.
- Sits between the top-level controller and the W-bit-unrolled state update.

Parameters:
- W, 1, message bits per beat; legal values 1, 2, 4, 8, 16, 32, 64, 128 (must divide KEY_W and INIT_STEPS).
- KEY_W, 128, key width in bits.
- IV_W, 128, IV width in bits; must equal KEY_W.
- INIT_STEPS, 1792, total initialization steps.
- BEATS, INIT_STEPS/W, derived; not overridable.
- CNT_W, $clog2(BEATS), derived beat-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE from any state.
- key_in  in  KEY_W  key; bit i = K[i].
- iv_in  in  IV_W  IV; bit i = IV[i].
- busy  out  1  high in RUN and DONE.
- m_valid  out  1  beat valid.
- m_ready  in  1  downstream accepts beat.
- m_data  out  W  message bits; lane j = m[beat*W + j].
- ca_out  out  W  ca control lanes; all ones while m_valid.
- cb_out  out  W  cb control lanes; all ones while m_valid.
- m_first  out  1  high on beat 0.
- m_last  out  1  high on beat BEATS-1.
- beat_idx  out  CNT_W  current beat index.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Message definition, step s in 0..INIT_STEPS-1:
  - s<128: m=K[s].
  - 128<=s<256: m=IV[s-128].
  - s=256: m=K[0]^1.
  - s>256: m=K[s mod 128].
- FSM states: IDLE, RUN, DONE.
- Reset (rst=0, async): state IDLE, counter 0, latched key/IV 0. All outputs 0: m_valid, m_data, ca_out, cb_out, m_first, m_last, beat_idx, busy, done.
- IDLE:
  - start=1 latches key_in/iv_in into internal registers, clears the counter, and moves to RUN.
  - Next cycle: m_valid=1, beat_idx=0, m_first=1. Start-to-first-beat latency is 1 cycle.
- RUN:
  - A beat transfers when m_valid & m_ready.
  - On transfer with counter<BEATS-1: counter increments; next beat is presented the following cycle. Full throughput: 1 beat/cycle when m_ready is held high.
  - On transfer with counter=BEATS-1: move to DONE; m_valid drops next cycle.
  - m_ready=0: m_data, ca_out, cb_out, beat_idx, m_first and m_last are held stable; no skipped or duplicated beats.
- All outputs are registered. m_data is computed from the latched key/IV only; key_in/iv_in changes after start have no effect.
- The beat containing s=256 (beat 256/W) inverts only lane 256 mod W. All other lanes of that beat follow the normal rule.
- ca_out/cb_out are all ones when m_valid=1, else 0.
- DONE: done=1, busy=1, m_valid=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- start while busy: ignored; no relatch and no counter disturbance.
- abort=1 in any state: next cycle IDLE, all outputs 0, counter 0. abort has priority over start and over a same-cycle transfer; no done pulse is generated.
- Reset mid-run: immediate return to reset values; no done pulse.
- Counter never wraps; BEATS-1 is the terminal value.
- Total cycles start→done with m_ready=1: BEATS+1 (done on cycle BEATS+1 after start).

Test Plan:
- W=1, key=0, iv=0, m_ready=1 → 1792 beats. m_data=1 only at beat 256, m_first on beat 0, m_last on beat 1791, done pulse 1793 cycles after start.
- W=8, key=128'h01, iv=128'hFF<<120, m_ready=1:
  - beat0 m_data=8'h01; beats 1-15=8'h00.
  - beat31=8'hFF; beat32=8'h00 (lane0 = K[0]^1 = 0).
  - beat48=8'h01; 224 beats total; ca_out=cb_out=8'hFF throughout.
- W=32, random m_ready (50%) → captured stream equals the golden model bit-for-bit. Data stable while m_ready=0; 56 transfers; exactly one done pulse.
- Start pulse at beat 10 of a run, plus key_in changed mid-run → no relatch; stream unchanged versus golden.
- abort asserted at beat 100 (W=1), same cycle as start-free transfer → IDLE next cycle, m_valid=0, no done. A new start then restarts from beat 0.
- rst driven low asynchronously mid-beat (between clock edges) at beat 500 → all outputs 0 immediately. After release, a start produces a full, correct 1792-beat sequence.
